// File: rtl/demux3x8_deser_pkg.sv
// Shared definitions for the 1:8 serial-to-parallel deserializer.
//   BYTE_W  : width of the assembled byte
//   CNT_W   : width of the bit-slot counter
//   state_e : two-state control FSM encoding (COLLECT / HOLD)
package demux3x8_deser_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

endpackage

// File: rtl/demux3x8_deser_if.sv
// Serial-in / byte-out handshake bundle for demux3x8_deser.
//   clear     : synchronous abort of the partial or held byte
//   in_valid  : serial bit offered on in_bit
//   in_bit    : serial data bit
//   in_ready  : deserializer accepts a bit this cycle
//   out_data  : assembled byte
//   out_valid : out_data holds a complete byte
//   out_ready : consumer takes the byte this cycle
//   bit_count : index of the next bit slot (before MSB_FIRST mapping)
// master = producer/consumer side, slave = deserializer side.
interface demux3x8_deser_if;
  import demux3x8_deser_pkg::*;

  logic              clear;
  logic              in_valid;
  logic              in_bit;
  logic              in_ready;
  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  bit_count;

  modport master (
    output clear, in_valid, in_bit, out_ready,
    input  in_ready, out_data, out_valid, bit_count
  );

  modport slave (
    input  clear, in_valid, in_bit, out_ready,
    output in_ready, out_data, out_valid, bit_count
  );

endinterface

// File: rtl/demux3x8_deser_decoder3x8.sv
// 3-to-8 one-hot decoder used to select the byte slot written on an accept.
//   sel_i    : 3-bit slot index
//   onehot_o : 8-bit one-hot select, bit sel_i set
module decoder3x8 (
  input  logic [2:0] sel_i,
  output logic [7:0] onehot_o
);

  always_comb begin
    onehot_o        = '0;
    onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/demux3x8_deser.sv
// Serial-to-parallel deserializer: receiving counterpart of the 8:1 bit-select
// mux. Bit k of a byte (k = accept order) is written back into slot k
// (MSB_FIRST=0) or slot 7-k (MSB_FIRST=1). After 8 accepts the byte is held
// with out_valid until the consumer handshakes, then cleared to zero.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : demux3x8_deser_if.slave handshake bundle
module demux3x8_deser
  import demux3x8_deser_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  demux3x8_deser_if.slave        bus
);

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] data_q,  data_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  logic [CNT_W-1:0]  slot;
  logic [BYTE_W-1:0] slot_sel;
  logic              accept;

  assign slot = MSB_FIRST ? (3'd7 - cnt_q) : cnt_q;

  decoder3x8 u_dec (
    .sel_i    (slot),
    .onehot_o (slot_sel)
  );

  // in_ready depends on state alone, so HOLD never bypasses into an accept.
  assign accept = bus.in_valid && (state_q == COLLECT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= COLLECT;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (bus.clear) begin
      state_d = COLLECT;
      data_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            data_d = (data_q & ~slot_sel) | (slot_sel & {BYTE_W{bus.in_bit}});
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_d = COLLECT;
            data_d  = '0;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = data_q;
  assign bus.bit_count = cnt_q;

endmodule
